// File: rtl/simple_unpacker.sv
// Splits OUT_SIZE-wide words from a small FIFO into two IN_SIZE-wide beats,
// low beat first, with m_last marking the high beat.
module simple_unpacker #(
    parameter int IN_SIZE  = 4,
    parameter int OUT_SIZE = IN_SIZE + 1,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [OUT_SIZE-1:0]          s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [IN_SIZE-1:0]           m_data,
    output logic                         m_last,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

    generate
        if (OUT_SIZE <= IN_SIZE || OUT_SIZE > 2 * IN_SIZE) begin : g_bad_width
            $error("simple_unpacker: OUT_SIZE must satisfy IN_SIZE < OUT_SIZE <= 2*IN_SIZE");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("simple_unpacker: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t              state;
    logic [OUT_SIZE-1:0] mem [DEPTH];
    logic [OUT_SIZE-1:0] hold;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // Readiness looks only at the registered pointers, so a same-cycle pop never frees a slot.
    assign s_ready = !rst && !full;
    assign push    = s_valid && s_ready;
    assign pop     = !empty && ((state == IDLE) || (state == HI && m_ready));
    assign level   = LW'(wr_ptr - rd_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold   <= '0;
            state  <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr[AW-1:0]];
            end
            case (state)
                IDLE: if (!empty) state <= LO;
                LO:   if (m_ready) state <= HI;
                HI:   if (m_ready) state <= empty ? IDLE : LO;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_valid = (state != IDLE);
        m_last  = (state == HI);
        m_data  = '0;
        case (state)
            LO:      m_data = hold[IN_SIZE-1:0];
            HI:      m_data = IN_SIZE'(hold[OUT_SIZE-1:IN_SIZE]);
            default: m_data = '0;
        endcase
    end
endmodule

// File: tb/tb_simple_unpacker.sv
// Directed bench for simple_unpacker: queue-based reference model checked every cycle,
// plus literal expectations for each scenario and an OUT_SIZE=8 instance.
module tb_simple_unpacker;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       s_valid, s_ready, m_valid, m_ready, m_last;
    logic [4:0] s_data;
    logic [3:0] m_data;
    logic [2:0] level;

    logic       s_valid2, s_ready2, m_valid2, m_ready2, m_last2;
    logic [7:0] s_data2;
    logic [3:0] m_data2;
    logic [2:0] level2;

    int checks = 0;
    int errors = 0;

    simple_unpacker #(.IN_SIZE(4), .OUT_SIZE(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .level(level)
    );

    simple_unpacker #(.IN_SIZE(4), .OUT_SIZE(8), .DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2), .level(level2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: words waiting in the FIFO, plus the word being split.
    logic [4:0] mq[$];
    logic [4:0] mhw;
    bit         mhv, mhi;
    int         cyc;
    logic [4:0] bq[$];   // accepted beats as {last, data}
    int         bcyc[$];

    initial begin
        bit had, mfull, mpush;
        mhv = 0; mhi = 0; mhw = '0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                mhv = 0; mhi = 0;
                chk("rst_s_ready", s_ready, 0);
                chk("rst_m_valid", m_valid, 0);
                chk("rst_level", level, 0);
            end else begin
                chk("m_valid", m_valid, mhv);
                chk("s_ready", s_ready, mq.size() != DEPTH);
                chk("level", level, mq.size());
                if (mhv) begin
                    chk("m_data", m_data, mhi ? {3'b000, mhw[4]} : mhw[3:0]);
                    chk("m_last", m_last, mhi);
                end
                if (m_valid && m_ready) begin
                    bq.push_back({m_last, m_data});
                    bcyc.push_back(cyc);
                end
                had   = mq.size() != 0;
                mfull = mq.size() == DEPTH;
                mpush = s_valid && !mfull;
                if (!mhv) begin
                    if (had) begin mhw = mq.pop_front(); mhv = 1; mhi = 0; end
                end else if (!mhi) begin
                    if (m_ready) mhi = 1;
                end else if (m_ready) begin
                    if (had) begin mhw = mq.pop_front(); mhi = 0; end
                    else begin mhv = 0; mhi = 0; end
                end
                if (mpush) mq.push_back(s_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] sent[$];
        logic [4:0] w;
        bit         acc;
        int         n, nacc;

        rst = 1'b1; s_valid = 0; s_data = '0; m_ready = 0;
        s_valid2 = 0; s_data2 = '0; m_ready2 = 0;
        step(); step();
        chk("lit_rst_s_ready", s_ready, 0);
        chk("lit_rst_m_data", m_data, 0);
        rst = 1'b0;
        step();
        chk("lit_rel_s_ready", s_ready, 1);

        // Single word 10110 -> beats 6 then 1
        s_valid = 1; s_data = 5'b10110; m_ready = 1;
        step();
        s_valid = 0; s_data = 5'h1F;
        chk("t1_idle_after_push", m_valid, 0);
        chk("t1_level1", level, 1);
        step();
        chk("t1_lo_valid", m_valid, 1);
        chk("t1_lo_data", m_data, 4'b0110);
        chk("t1_lo_last", m_last, 0);
        step();
        chk("t1_hi_data", m_data, 4'b0001);
        chk("t1_hi_last", m_last, 1);
        step();
        chk("t1_done_valid", m_valid, 0);
        chk("t1_done_level", level, 0);

        // Back-to-back words, no bubbles
        bq.delete(); bcyc.delete();
        s_valid = 1; s_data = 5'h1F; step();
        s_data = 5'h00; step();
        s_data = 5'h15; step();
        s_valid = 0;
        repeat (8) step();
        chk("t2_beats", bq.size(), 6);
        if (bq.size() == 6) begin
            chk("t2_b0", bq[0], 5'h0F); chk("t2_b1", bq[1], 5'h11);
            chk("t2_b2", bq[2], 5'h00); chk("t2_b3", bq[3], 5'h10);
            chk("t2_b4", bq[4], 5'h05); chk("t2_b5", bq[5], 5'h11);
            chk("t2_no_bubble", bcyc[5] - bcyc[0], 5);
        end

        // Fill with the consumer stalled: DEPTH+1 words fit
        bq.delete(); sent.delete();
        m_ready = 0; s_valid = 1; nacc = 0;
        for (int i = 0; i < 10; i++) begin
            w = 5'(i * 7 + 3);
            s_data = w;
            if (s_ready) begin nacc++; sent.push_back(w); end
            step();
        end
        s_valid = 0;
        chk("t3_accepted", nacc, DEPTH + 1);
        chk("t3_level_full", level, DEPTH);
        chk("t3_s_ready_low", s_ready, 0);
        chk("t3_head_lo", m_data, 4'h3);
        m_ready = 1;
        repeat (14) step();
        chk("t3_beats", bq.size(), 2 * sent.size());
        if (bq.size() == 2 * sent.size())
            for (int k = 0; k < sent.size(); k++) begin
                chk("t3_lo", bq[2*k],   {1'b0, sent[k][3:0]});
                chk("t3_hi", bq[2*k+1], {1'b1, 3'b000, sent[k][4]});
            end

        // Random back-pressure over 20 words, wraps the pointers several times
        bq.delete(); sent.delete();
        for (int i = 0; i < 20; i++) begin
            w = 5'($urandom);
            s_valid = 1; s_data = w; n = 0;
            do begin
                acc = s_ready;
                m_ready = 1'($urandom_range(0, 1));
                step();
                n++;
            end while (!acc && n < 50);
            if (acc) sent.push_back(w);
            else chk("t4_push_timeout", 0, 1);
        end
        s_valid = 0; n = 0;
        while (bq.size() < 40 && n < 300) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m_ready = 1;
        repeat (3) step();
        chk("t4_beats", bq.size(), 40);
        if (bq.size() == 40 && sent.size() == 20)
            for (int k = 0; k < 20; k++) begin
                chk("t4_lo", bq[2*k],   {1'b0, sent[k][3:0]});
                chk("t4_hi", bq[2*k+1], {1'b1, 3'b000, sent[k][4]});
            end

        // Reset while in HI with 3 words in the FIFO
        m_ready = 0; s_valid = 1;
        s_data = 5'h11; step();
        s_data = 5'h12; step();
        s_data = 5'h13; step();
        s_data = 5'h14; step();
        s_valid = 0;
        m_ready = 1; step();
        m_ready = 0;
        chk("t5_in_hi", m_last, 1);
        chk("t5_level3", level, 3);
        rst = 1; #1;
        chk("t5_async_m_valid", m_valid, 0);
        chk("t5_async_level", level, 0);
        chk("t5_async_s_ready", s_ready, 0);
        step();
        rst = 0;
        m_ready = 1;
        step(); step();
        chk("t5_quiet", m_valid, 0);
        bq.delete();
        s_valid = 1; s_data = 5'h0A; step();
        s_valid = 0;
        repeat (6) step();
        chk("t5_beats", bq.size(), 2);
        if (bq.size() == 2) begin
            chk("t5_b0", bq[0], 5'h0A);
            chk("t5_b1", bq[1], 5'h10);
        end

        // OUT_SIZE=8 instance: C3 -> 3 then C
        s_valid2 = 1; s_data2 = 8'hC3; m_ready2 = 1;
        step();
        s_valid2 = 0;
        step();
        chk("w8_lo_valid", m_valid2, 1);
        chk("w8_lo_data", m_data2, 4'h3);
        chk("w8_lo_last", m_last2, 0);
        step();
        chk("w8_hi_data", m_data2, 4'hC);
        chk("w8_hi_last", m_last2, 1);
        step();
        chk("w8_done", m_valid2, 0);
        chk("w8_level", level2, 0);
        chk("w8_s_ready", s_ready2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_unpacker.md
Name: simple_unpacker

Overview:
- Reader-side counterpart to the `simple` datapath.
- Accepts OUT_SIZE-wide result words over a valid/ready stream, buffers them in a small FIFO, and re-emits each word as two IN_SIZE-wide beats: low beat first, then high beat.
- Sits between a `simple` result stream and an IN_SIZE-wide consumer such as a narrow bus or serial link.

Parameters:
- IN_SIZE, 4, width of each output beat.
- OUT_SIZE, IN_SIZE+1, width of each input word. Legal range: IN_SIZE < OUT_SIZE <= 2*IN_SIZE; elaboration error otherwise.
- DEPTH, 4, FIFO depth in words. Power of two, >= 2.

Ports:
- clk  in  1  sole clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high. One clock; all flops reset by rst.
- s_valid  in  1  input word valid.
- s_ready  out  1  input can accept.
- s_data  in  OUT_SIZE  input word.
- m_valid  out  1  output beat valid.
- m_ready  in  1  consumer accepts beat.
- m_data  out  IN_SIZE  output beat.
- m_last  out  1  high on the high (second) beat of a word.
- level  out  $clog2(DEPTH+1)  words held in FIFO, excluding the word in the holding register.

Behaviour:
- Reset values: s_ready=0 while rst is asserted, 1 on the first cycle after release; m_valid=0, m_data=0, m_last=0, level=0, state=IDLE, FIFO pointers=0.
- Push: occurs when s_valid && s_ready at a rising edge; the word is written at wr_ptr.
- s_ready = !full, computed from the registered count only. A pop in the same cycle does not free a slot for a push when full.
- FIFO: wr_ptr/rd_ptr are log2(DEPTH)+1 bits with wrap-around. Full = MSBs differ and low bits are equal; empty = pointers equal.
- Holding register captures the FIFO head on a pop. State machine:
  - IDLE: m_valid=0. If the FIFO is non-empty, pop into hold and go to LO.
  - LO: m_valid=1, m_data=hold[IN_SIZE-1:0], m_last=0. On m_ready, go to HI; otherwise hold.
  - HI: m_valid=1, m_data = hold[OUT_SIZE-1:IN_SIZE] zero-extended to IN_SIZE, m_last=1. On m_ready: if the FIFO is non-empty, pop and go to LO; else go to IDLE. Otherwise hold.
- Outputs m_valid/m_data/m_last are registered, or decoded purely from registered state and hold.
- Latency: a word pushed at edge N into an empty FIFO with the block in IDLE is popped at edge N+1; m_valid is high after edge N+1.
- Throughput: one word per 2 cycles with m_ready held high. No IDLE bubble between words when the FIFO is non-empty at the HI->LO transition.
- Capacity: DEPTH+1 words total (DEPTH in FIFO plus 1 in hold) before s_ready drops, with m_ready low.
- Simultaneous push and pop when neither full nor empty: level is unchanged, both pointers advance.
- Push into an empty FIFO while in HI with m_ready=1: no same-cycle bypass; go to IDLE, then pop next cycle (one bubble).
- m_data/m_last must stay stable while m_valid && !m_ready.
- s_data is ignored when s_valid=0 or s_ready=0.
- Reset mid-operation: all buffered words are dropped; outputs return to reset values asynchronously; no beats are emitted after release until a new push.
- level = wr_ptr - rd_ptr (modulo pointer width), range 0..DEPTH.

Test Plan:
- Reset then single push s_data=5'b10110, m_ready=1 -> m_valid high 1 cycle after push; beats 4'b0110 (m_last=0) then 4'b0001 (m_last=1); m_valid low after; level returns to 0.
- Back-to-back push 5'h1F, 5'h00, 5'h15, m_ready=1 -> beats F,1,0,0,5,1 on consecutive cycles after first valid, m_last on every 2nd beat, no bubbles.
- m_ready=0, push continuously with s_valid=1 -> exactly 5 words accepted (DEPTH=4), then s_ready=0 and level=4. Raise m_ready -> all 10 beats emerge in order; s_ready re-asserts the cycle after level drops below 4.
- Random m_ready (50% toggling) during 20-word stream -> m_data/m_last stable while stalled; scoreboard matches every word split; no loss or duplication across pointer wrap.
- Assert rst for 1 cycle while in HI with 3 words buffered -> m_valid=0 immediately, level=0; after release, push 5'h0A -> beats A then 0 only.
- OUT_SIZE=8, IN_SIZE=4 build, push 8'hC3 -> beats 3 then C, m_last on C.
